// File: rtl/pipeline_tracker.sv
// Stage-occupancy and hazard-feedback tracker for a 5-stage MIPS pipeline.
// Mirrors the controller's stage reset/enable commands into registered valid/destination state and perf counters.
module pipeline_tracker #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_rst,
  input  logic             id_rst,
  input  logic             exe_rst,
  input  logic             mem_rst,
  input  logic             wb_rst,
  input  logic             if_en,
  input  logic             id_en,
  input  logic             exe_en,
  input  logic             mem_en,
  input  logic             wb_en,
  input  logic             id_wb_wen,
  input  logic [4:0]       id_wb_addr,
  input  logic             id_mem_ren,
  input  logic [4:0]       id_addr_rs,
  input  logic [4:0]       id_addr_rt,
  input  logic             cnt_clr,
  output logic             if_valid,
  output logic             id_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [4:0]       regw_addr_exe,
  output logic [4:0]       regw_addr_mem,
  output logic [4:0]       regw_addr_wb,
  output logic             wb_wen_exe,
  output logic             wb_wen_mem,
  output logic             wb_wen_wb,
  output logic             mem_ren_mem,
  output logic [4:0]       addr_rs_exe,
  output logic [4:0]       addr_rt_exe,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             if_valid_q, if_valid_d;
  logic             id_valid_q, id_valid_d;
  logic             exe_valid_q, exe_valid_d;
  logic             exe_wen_q, exe_wen_d;
  logic [4:0]       exe_waddr_q, exe_waddr_d;
  logic             exe_ren_q, exe_ren_d;
  logic [4:0]       exe_rs_q, exe_rs_d;
  logic [4:0]       exe_rt_q, exe_rt_d;
  logic             mem_valid_q, mem_valid_d;
  logic             mem_wen_q, mem_wen_d;
  logic [4:0]       mem_waddr_q, mem_waddr_d;
  logic             mem_ren_q, mem_ren_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_wen_q, wb_wen_d;
  logic [4:0]       wb_waddr_q, wb_waddr_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic             retire_inc_s;
  logic             bubble_inc_s;

  // IF and ID stage next state: reset beats enable, otherwise hold.
  always_comb begin
    if_valid_d = if_valid_q;
    id_valid_d = id_valid_q;
    if (if_rst) begin
      if_valid_d = 1'b0;
    end else if (if_en) begin
      if_valid_d = 1'b1;
    end else begin
      if_valid_d = if_valid_q;
    end
    if (id_rst) begin
      id_valid_d = 1'b0;
    end else if (id_en) begin
      id_valid_d = if_valid_q;
    end else begin
      id_valid_d = id_valid_q;
    end
  end

  // EXE entry qualifies wen/ren with id_valid so downstream flags never outlive validity.
  always_comb begin
    exe_valid_d = exe_valid_q;
    exe_wen_d   = exe_wen_q;
    exe_waddr_d = exe_waddr_q;
    exe_ren_d   = exe_ren_q;
    exe_rs_d    = exe_rs_q;
    exe_rt_d    = exe_rt_q;
    if (exe_rst) begin
      exe_valid_d = 1'b0;
      exe_wen_d   = 1'b0;
      exe_waddr_d = 5'd0;
      exe_ren_d   = 1'b0;
      exe_rs_d    = 5'd0;
      exe_rt_d    = 5'd0;
    end else if (exe_en) begin
      exe_valid_d = id_valid_q;
      exe_wen_d   = id_wb_wen & id_valid_q;
      exe_waddr_d = id_wb_addr;
      exe_ren_d   = id_mem_ren & id_valid_q;
      exe_rs_d    = id_addr_rs;
      exe_rt_d    = id_addr_rt;
    end else begin
      exe_valid_d = exe_valid_q;
    end
  end

  // MEM and WB stage next state.
  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_wen_d   = mem_wen_q;
    mem_waddr_d = mem_waddr_q;
    mem_ren_d   = mem_ren_q;
    wb_valid_d  = wb_valid_q;
    wb_wen_d    = wb_wen_q;
    wb_waddr_d  = wb_waddr_q;
    if (mem_rst) begin
      mem_valid_d = 1'b0;
      mem_wen_d   = 1'b0;
      mem_waddr_d = 5'd0;
      mem_ren_d   = 1'b0;
    end else if (mem_en) begin
      mem_valid_d = exe_valid_q;
      mem_wen_d   = exe_wen_q;
      mem_waddr_d = exe_waddr_q;
      mem_ren_d   = exe_ren_q;
    end else begin
      mem_valid_d = mem_valid_q;
    end
    if (wb_rst) begin
      wb_valid_d = 1'b0;
      wb_wen_d   = 1'b0;
      wb_waddr_d = 5'd0;
    end else if (wb_en) begin
      wb_valid_d = mem_valid_q;
      wb_wen_d   = mem_wen_q;
      wb_waddr_d = mem_waddr_q;
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // A bubble is an EXE clear while IF is frozen but not flushed, i.e. a load stall.
  assign retire_inc_s = wb_valid_q & wb_en & ~wb_rst;
  assign bubble_inc_s = exe_rst & ~if_rst & ~if_en;

  // Performance counters; clear has priority over increment.
  always_comb begin
    retire_d = retire_q;
    bubble_d = bubble_q;
    if (cnt_clr) begin
      retire_d = {CNT_W{1'b0}};
      bubble_d = {CNT_W{1'b0}};
    end else begin
      if (retire_inc_s) begin
        retire_d = retire_q + CNT_W'(1);
      end else begin
        retire_d = retire_q;
      end
      if (bubble_inc_s) begin
        bubble_d = bubble_q + CNT_W'(1);
      end else begin
        bubble_d = bubble_q;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q  <= 1'b0;
      id_valid_q  <= 1'b0;
      exe_valid_q <= 1'b0;
      exe_wen_q   <= 1'b0;
      exe_waddr_q <= 5'd0;
      exe_ren_q   <= 1'b0;
      exe_rs_q    <= 5'd0;
      exe_rt_q    <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_waddr_q <= 5'd0;
      mem_ren_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_wen_q    <= 1'b0;
      wb_waddr_q  <= 5'd0;
      retire_q    <= {CNT_W{1'b0}};
      bubble_q    <= {CNT_W{1'b0}};
    end else begin
      if_valid_q  <= if_valid_d;
      id_valid_q  <= id_valid_d;
      exe_valid_q <= exe_valid_d;
      exe_wen_q   <= exe_wen_d;
      exe_waddr_q <= exe_waddr_d;
      exe_ren_q   <= exe_ren_d;
      exe_rs_q    <= exe_rs_d;
      exe_rt_q    <= exe_rt_d;
      mem_valid_q <= mem_valid_d;
      mem_wen_q   <= mem_wen_d;
      mem_waddr_q <= mem_waddr_d;
      mem_ren_q   <= mem_ren_d;
      wb_valid_q  <= wb_valid_d;
      wb_wen_q    <= wb_wen_d;
      wb_waddr_q  <= wb_waddr_d;
      retire_q    <= retire_d;
      bubble_q    <= bubble_d;
    end
  end

  assign if_valid      = if_valid_q;
  assign id_valid      = id_valid_q;
  assign exe_valid     = exe_valid_q;
  assign mem_valid     = mem_valid_q;
  assign wb_valid      = wb_valid_q;
  assign regw_addr_exe = exe_waddr_q;
  assign regw_addr_mem = mem_waddr_q;
  assign regw_addr_wb  = wb_waddr_q;
  assign wb_wen_exe    = exe_wen_q;
  assign wb_wen_mem    = mem_wen_q;
  assign wb_wen_wb     = wb_wen_q;
  assign mem_ren_mem   = mem_ren_q;
  assign addr_rs_exe   = exe_rs_q;
  assign addr_rt_exe   = exe_rt_q;
  assign retire_cnt    = retire_q;
  assign bubble_cnt    = bubble_q;

endmodule

// File: tb/tb_pipeline_tracker.sv
// Directed bench for pipeline_tracker: expectations are queued with a due cycle and checked when that cycle arrives.
module tb_pipeline_tracker;
  localparam int CW = 4;

  localparam int S_IFV = 0, S_IDV = 1, S_EXEV = 2, S_MEMV = 3, S_WBV = 4;
  localparam int S_WAE = 5, S_WAM = 6, S_WAW = 7, S_WENE = 8, S_WENM = 9, S_WENW = 10;
  localparam int S_RENM = 11, S_RS = 12, S_RT = 13, S_RET = 14, S_BUB = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic if_en, id_en, exe_en, mem_en, wb_en;
  logic id_wb_wen, id_mem_ren, cnt_clr;
  logic [4:0] id_wb_addr, id_addr_rs, id_addr_rt;
  logic if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic [4:0] regw_addr_exe, regw_addr_mem, regw_addr_wb, addr_rs_exe, addr_rt_exe;
  logic wb_wen_exe, wb_wen_mem, wb_wen_wb, mem_ren_mem;
  logic [CW-1:0] retire_cnt, bubble_cnt;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_tracker #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
    .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
    .id_wb_wen(id_wb_wen), .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren),
    .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt), .cnt_clr(cnt_clr),
    .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
    .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem), .regw_addr_wb(regw_addr_wb),
    .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem), .wb_wen_wb(wb_wen_wb),
    .mem_ren_mem(mem_ren_mem), .addr_rs_exe(addr_rs_exe), .addr_rt_exe(addr_rt_exe),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_IFV:   obs = {31'd0, if_valid};
      S_IDV:   obs = {31'd0, id_valid};
      S_EXEV:  obs = {31'd0, exe_valid};
      S_MEMV:  obs = {31'd0, mem_valid};
      S_WBV:   obs = {31'd0, wb_valid};
      S_WAE:   obs = {27'd0, regw_addr_exe};
      S_WAM:   obs = {27'd0, regw_addr_mem};
      S_WAW:   obs = {27'd0, regw_addr_wb};
      S_WENE:  obs = {31'd0, wb_wen_exe};
      S_WENM:  obs = {31'd0, wb_wen_mem};
      S_WENW:  obs = {31'd0, wb_wen_wb};
      S_RENM:  obs = {31'd0, mem_ren_mem};
      S_RS:    obs = {27'd0, addr_rs_exe};
      S_RT:    obs = {27'd0, addr_rt_exe};
      S_RET:   obs = {28'd0, retire_cnt};
      S_BUB:   obs = {28'd0, bubble_cnt};
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sname(input int sel);
    case (sel)
      S_IFV:   sname = "if_valid";
      S_IDV:   sname = "id_valid";
      S_EXEV:  sname = "exe_valid";
      S_MEMV:  sname = "mem_valid";
      S_WBV:   sname = "wb_valid";
      S_WAE:   sname = "regw_addr_exe";
      S_WAM:   sname = "regw_addr_mem";
      S_WAW:   sname = "regw_addr_wb";
      S_WENE:  sname = "wb_wen_exe";
      S_WENM:  sname = "wb_wen_mem";
      S_WENW:  sname = "wb_wen_wb";
      S_RENM:  sname = "mem_ren_mem";
      S_RS:    sname = "addr_rs_exe";
      S_RT:    sname = "addr_rt_exe";
      S_RET:   sname = "retire_cnt";
      S_BUB:   sname = "bubble_cnt";
      default: sname = "unknown";
    endcase
  endfunction

  task automatic check(input int sel, input logic [31:0] exp);
    logic [31:0] o;
    o = obs(sel);
    n_assert++;
    assert (o === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", sname(sel), cyc, o, exp);
    end
  endtask

  task automatic check_all_zero();
    for (int s = 0; s < 16; s++) check(s, 32'd0);
  endtask

  task automatic expect_at(input int d, input int sel, input logic [31:0] e);
    exp_t x;
    x.due = cyc + d;
    x.sel = sel;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic step();
    exp_t keep[$];
    @(posedge clk);
    cyc++;
    #1;
    foreach (sb_q[i]) begin
      if (sb_q[i].due == cyc) check(sb_q[i].sel, sb_q[i].exp);
      else keep.push_back(sb_q[i]);
    end
    sb_q = keep;
  endtask

  task automatic set_defaults();
    if_rst = 1'b0; id_rst = 1'b0; exe_rst = 1'b0; mem_rst = 1'b0; wb_rst = 1'b0;
    if_en = 1'b1; id_en = 1'b1; exe_en = 1'b1; mem_en = 1'b1; wb_en = 1'b1;
    cnt_clr = 1'b0;
  endtask

  task automatic drive_id(input logic wen, input logic [4:0] addr, input logic ren,
                          input logic [4:0] rs, input logic [4:0] rt);
    id_wb_wen = wen; id_wb_addr = addr; id_mem_ren = ren; id_addr_rs = rs; id_addr_rt = rt;
  endtask

  initial begin
    set_defaults();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    #1 rst_n = 1'b0;
    #1 check_all_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;

    // Refill after reset release: one stage per edge.
    expect_at(1, S_IFV, 1); expect_at(1, S_IDV, 0);
    expect_at(2, S_IDV, 1); expect_at(2, S_EXEV, 0);
    expect_at(3, S_EXEV, 1); expect_at(3, S_MEMV, 0);
    expect_at(4, S_MEMV, 1); expect_at(4, S_WBV, 0);
    expect_at(5, S_WBV, 1); expect_at(5, S_RET, 0);
    expect_at(6, S_RET, 1); expect_at(6, S_BUB, 0);
    repeat (6) step();

    // I1: load into r8.
    drive_id(1'b1, 5'd8, 1'b1, 5'd3, 5'd4);
    expect_at(1, S_EXEV, 1); expect_at(1, S_WAE, 8); expect_at(1, S_WENE, 1);
    expect_at(1, S_RS, 3); expect_at(1, S_RT, 4);
    expect_at(2, S_WAM, 8); expect_at(2, S_RENM, 1); expect_at(2, S_WENM, 1);
    expect_at(3, S_WAW, 8); expect_at(3, S_WENW, 1);
    step();

    // I2: ALU op into r12.
    drive_id(1'b1, 5'd12, 1'b0, 5'd5, 5'd6);
    expect_at(1, S_WAE, 12);
    expect_at(2, S_WAM, 12); expect_at(2, S_RENM, 0);
    expect_at(3, S_WAW, 12); expect_at(3, S_WENW, 1);
    step();

    // I3 waits in ID under a load stall.
    drive_id(1'b1, 5'd9, 1'b0, 5'd7, 5'd1);
    if_en = 1'b0; id_en = 1'b0; exe_rst = 1'b1;
    expect_at(1, S_EXEV, 0); expect_at(1, S_WENE, 0); expect_at(1, S_WAE, 0); expect_at(1, S_RS, 0);
    expect_at(1, S_IFV, 1); expect_at(1, S_IDV, 1); expect_at(1, S_BUB, 1);
    expect_at(2, S_MEMV, 0); expect_at(2, S_WENM, 0); expect_at(2, S_WAM, 0);
    step();
    set_defaults();
    expect_at(1, S_EXEV, 1); expect_at(1, S_WAE, 9); expect_at(1, S_RS, 7); expect_at(1, S_RT, 1);
    expect_at(1, S_BUB, 1);
    step();

    // I4 enters EXE while ID is cleared behind it.
    id_rst = 1'b1;
    drive_id(1'b1, 5'd11, 1'b1, 5'd0, 5'd0);
    expect_at(1, S_IDV, 0); expect_at(1, S_WENE, 1); expect_at(2, S_RENM, 1);
    step();

    // Invalid ID slot with wen/ren asserted must not propagate them.
    id_rst = 1'b0;
    drive_id(1'b1, 5'd13, 1'b1, 5'd2, 5'd2);
    expect_at(1, S_EXEV, 0); expect_at(1, S_WENE, 0); expect_at(1, S_WAE, 13); expect_at(1, S_IDV, 1);
    expect_at(2, S_MEMV, 0); expect_at(2, S_RENM, 0); expect_at(2, S_WENM, 0);
    step();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    step();

    // Global flush does not count as a bubble.
    if_rst = 1'b1; id_rst = 1'b1; exe_rst = 1'b1; mem_rst = 1'b1; wb_rst = 1'b1;
    for (int s = S_IFV; s <= S_WBV; s++) expect_at(1, s, 0);
    expect_at(1, S_WENE, 0); expect_at(1, S_WENM, 0); expect_at(1, S_WENW, 0);
    expect_at(1, S_RENM, 0); expect_at(1, S_BUB, 1);
    step();
    set_defaults();
    expect_at(1, S_IFV, 1); expect_at(2, S_IDV, 1);
    repeat (2) step();

    // Asynchronous reset in the middle of a stall cycle.
    if_en = 1'b0; id_en = 1'b0; exe_rst = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_defaults();
    cyc = 0;
    expect_at(1, S_IFV, 1); expect_at(1, S_IDV, 0);
    expect_at(2, S_IDV, 1); expect_at(2, S_EXEV, 0);
    expect_at(3, S_EXEV, 1); expect_at(5, S_WBV, 1);
    repeat (5) step();

    // Clear wins over a concurrent retire, then count through the wrap.
    cnt_clr = 1'b1;
    expect_at(1, S_RET, 0); expect_at(1, S_BUB, 0);
    step();
    cnt_clr = 1'b0;
    expect_at(14, S_RET, 14); expect_at(15, S_RET, 15);
    expect_at(16, S_RET, 0); expect_at(17, S_RET, 1);
    repeat (17) step();
    wb_en = 1'b0;
    expect_at(1, S_RET, 1); expect_at(1, S_WBV, 1);
    step();
    wb_en = 1'b1;
    expect_at(1, S_RET, 2);
    step();

    // Reset and enable on the same stage: reset wins.
    if_rst = 1'b1;
    expect_at(1, S_IFV, 0); expect_at(1, S_IDV, 1); expect_at(2, S_IDV, 0); expect_at(1, S_BUB, 0);
    step();
    if_rst = 1'b0;
    expect_at(1, S_IFV, 1);
    repeat (3) step();

    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_tracker.md
# pipeline_tracker

Stage-occupancy and hazard-feedback tracker for the MIPS 5-stage pipelined CPU. It sits opposite the pipeline controller: it takes the controller's per-stage reset/enable commands plus the ID-stage decode results. It returns the per-stage valid flags and the registered EXE/MEM/WB destination, write-enable and load information that the controller uses for forwarding and load-stall decisions. It also keeps retire and stall-bubble performance counters.

## Interface
- CNT_W, 32, width of performance counters
- clk  input  1  main clock, rising edge
- rst_n  input  1  **asynchronous, active-low reset**
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  input  1 each  synchronous stage clear from controller
- if_en, id_en, exe_en, mem_en, wb_en  input  1 each  stage advance enable from controller
- id_wb_wen  input  1  ID instruction writes a register
- id_wb_addr  input  5  resolved ID destination (rd/rt/31 already selected)
- id_mem_ren  input  1  ID instruction is a load
- id_addr_rs, id_addr_rt  input  5 each  ID source register fields
- cnt_clr  input  1  synchronous counter clear
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  output  1 each  stage holds a real instruction
- regw_addr_exe, regw_addr_mem, regw_addr_wb  output  5 each  stage destination register
- wb_wen_exe, wb_wen_mem, wb_wen_wb  output  1 each  stage will write the register file
- mem_ren_mem  output  1  MEM-stage instruction is a load
- addr_rs_exe, addr_rt_exe  output  5 each  EXE-stage source fields
- retire_cnt  output  CNT_W  instructions retired
- bubble_cnt  output  CNT_W  stall bubbles inserted

## Operation
- Each stage N has a register set {valid, wen, waddr, [ren], [rs, rt]}. It updates on the rising edge of clk by priority:
  - N_rst=1: clear all fields to 0.
  - else N_en=1: load from the upstream stage.
  - else: hold.
- IF stage: the upstream value is valid=1 (the fetch unit always supplies an instruction).
- ID stage: valid is loaded from if_valid.
- EXE stage loads:
  - valid <= id_valid
  - wb_wen_exe <= id_wb_wen & id_valid
  - regw_addr_exe <= id_wb_addr
  - mem_ren <= id_mem_ren & id_valid
  - addr_rs_exe, addr_rt_exe from the ID fields
- MEM stage loads the EXE fields; mem_ren_mem follows the EXE mem_ren.
- WB stage loads the MEM fields. It has no ren or rs/rt fields.
- Write-enable invariant: a wen or ren output is never 1 while the corresponding stage valid is 0. This is guaranteed by qualifying the fields at EXE entry and clearing them on stage reset.
- retire_cnt increments when wb_valid=1, wb_en=1 and wb_rst=0, i.e. the instruction leaves WB.
- bubble_cnt increments when exe_rst=1, if_rst=0 and if_en=0. This is the load-stall pattern; a global flush (all *_rst=1) does not count.
- Counters wrap modulo 2^CNT_W. cnt_clr=1 zeroes both counters and takes priority over an increment in the same cycle.

## Timing
- rst_n=0 immediately (asynchronously) clears every output to 0: all valids, wens, mem_ren_mem, addresses and both counters. Release is sampled synchronously on the next rising edge.
- Pipeline latency: one cycle per stage. An instruction is in ID at cycle t, then in EXE at t+1, MEM at t+2 and WB at t+3, with full enables.
- Outputs are purely registered; there is no combinational path from any input to any output.
- Stall (if_en=0, id_en=0, exe_rst=1):
  - IF and ID hold their contents.
  - EXE becomes an invalid bubble with wb_wen_exe=0.
  - MEM and WB keep advancing.
- Same stage with N_rst=1 and N_en=1: reset wins.
- Same stage with N_rst=0 and N_en=0: hold, including counters unaffected except retire (which requires wb_en).
- An asynchronous rst_n assertion mid-stall or mid-flush overrides everything. After release the pipeline refills from IF with id_valid first asserting one edge after if_valid.
- retire_cnt at 2^CNT_W-1 plus one retire wraps to 0.

## Test plan
- Reset:
  - assert rst_n=0 mid-cycle -> all outputs 0 before the next edge.
  - release with all en=1, rst=0 -> if_valid=1 at edge 1, id_valid at 2, exe_valid at 3, mem_valid at 4, wb_valid at 5.
- Flow:
  - ID presents id_wb_wen=1, id_wb_addr=5'd8, id_mem_ren=1, id_valid=1 -> regw_addr_exe=8 and wb_wen_exe=1 next cycle.
  - The following cycle: regw_addr_mem=8, mem_ren_mem=1, wb_wen_mem=1.
  - The cycle after: regw_addr_wb=8, wb_wen_wb=1.
- Load stall:
  - one cycle of if_en=0, id_en=0, exe_rst=1 -> exe_valid=0, wb_wen_exe=0, ID fields unchanged, bubble_cnt +1.
  - The prior EXE contents appear in MEM.
- Invalid capture: id_valid=0 with id_wb_wen=1 and id_mem_ren=1 -> wb_wen_exe=0 and mem_ren_mem later 0.
- Global flush: all *_rst=1 for one cycle -> all valids 0, bubble_cnt unchanged.
- Counters:
  - preload retire_cnt to 32'hFFFF_FFFF via 2^32-1 retires (or force) and retire one -> 0.
  - cnt_clr=1 concurrent with a retire -> retire_cnt=0.
